cond_unit: RTL

//  Conditional-execution unit directly downstream of the instruction decoder.

---
 rtl/cond_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, condition evaluation,
// write-strobe gating and executed/squashed instruction counters.
module cond_unit #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             MemB,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemByte,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] InstrCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             cond_pass;
  logic             cond_ex;
  logic             n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Evaluate the condition field against the registered flags only
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Zero-latency strobe gating; reset suppresses everything in its cycle
  always_comb begin
    cond_ex  = En & cond_pass & ~reset;
    CondEx   = cond_ex;
    PCSrc    = PCS  & cond_ex;
    RegWrite = RegW & cond_ex;
    MemWrite = MemW & cond_ex;
    MemByte  = MemB & cond_ex;
  end

  // Next-state for flags (independent N,Z / C,V halves) and counters
  always_comb begin
    flags_d      = flags_q;
    instr_cnt_d  = instr_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (cond_ex) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
    if (En & ~cond_pass) begin
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= FLAG_RST;
      instr_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      flags_q      <= flags_d;
      instr_cnt_q  <= instr_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign Flags     = flags_q;
  assign InstrCnt  = instr_cnt_q;
  assign SquashCnt = squash_cnt_q;

endmodule
